// File: rtl/alu_sched_pkg.sv
// Shared opcode constants and FSM state encoding for the shared-ALU arbiter.
package alu_sched_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_NOT  = 2'b10;
    localparam logic [1:0] OP_BIT0 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu8_core.sv
// Combinational 8-bit ALU: ADD with carry-out, AND, NOT, BIT0.
module alu8_core
    import alu_sched_pkg::*;
(
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] da,
    input  logic [DATA_W-1:0] db,
    output logic [DATA_W-1:0] res,
    output logic              cout
);

    always_comb begin
        res  = '0;
        cout = 1'b0;
        case (op)
            OP_ADD:  {cout, res} = {1'b0, da} + {1'b0, db};
            OP_AND:  res = da & db;
            OP_NOT:  res = ~da;
            OP_BIT0: res = {{(DATA_W-1){1'b0}}, da[0]};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Two-requester round-robin arbiter sharing one alu8_core through IDLE/EXEC/DONE.
// Optional zero-result flag output enabled by defining ALU_ZERO_FLAG_EN.
module alu_share_arb
    import alu_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [1:0]        op0,
    input  logic [1:0]        op1,
    input  logic [DATA_W-1:0] da0,
    input  logic [DATA_W-1:0] db0,
    input  logic [DATA_W-1:0] da1,
    input  logic [DATA_W-1:0] db1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] res,
    output logic              cout,
    output logic              res_valid,
    output logic              res_id,
    output logic              busy
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic              zero
`endif
);

    state_t            state, state_nxt;
    logic              rr_ptr;
    logic              grant_vld;
    logic              grant_id;
    logic              id_p0;
    logic [1:0]        op_p0;
    logic [DATA_W-1:0] da_p0, db_p0;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cout;

    // rr_ptr names the requester that wins when both ask at once
    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant_vld = 1'b1;
                    grant_id  = (req0 && req1) ? rr_ptr : req1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rr_ptr <= 1'b0;
            id_p0  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_vld) begin
                rr_ptr <= ~grant_id;
                id_p0  <= grant_id;
            end
        end
    end

    // Stage p0: operands captured at grant, later input changes are ignored
    always_ff @(posedge clk) begin
        if (grant_vld) begin
            op_p0 <= grant_id ? op1 : op0;
            da_p0 <= grant_id ? da1 : da0;
            db_p0 <= grant_id ? db1 : db0;
        end
    end

    alu8_core u_alu (
        .op   (op_p0),
        .da   (da_p0),
        .db   (db_p0),
        .res  (alu_res),
        .cout (alu_cout)
    );

    // Stage p1: result registers, loaded only in EXEC and held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res    <= '0;
            cout   <= 1'b0;
            res_id <= 1'b0;
        end else if (state == ST_EXEC) begin
            res    <= alu_res;
            cout   <= alu_cout;
            res_id <= id_p0;
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero <= 1'b0;
        end else if (state == ST_EXEC) begin
            zero <= (alu_res == '0);
        end
    end
`endif

    assign res_valid = (state == ST_DONE);
    assign ack0      = res_valid && !res_id;
    assign ack1      = res_valid && res_id;
    assign busy      = (state != ST_IDLE);

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 The block SHALL have these ports, listed as name, direction, width, meaning:
  clk  in  1  single clock, rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  req0 / req1  in  1 each  request from requester 0 / requester 1.
  op0 / op1  in  2 each  opcode: 00 ADD, 01 AND, 10 NOT, 11 BIT0.
  da0, db0 / da1, db1  in  8 each  operands.
  ack0 / ack1  out  1 each  one-cycle completion pulse.
  res  out  8  registered result.
  cout  out  1  ADD carry; 0 for other ops.
  res_valid  out  1  one-cycle result strobe.
  res_id  out  1  requester served.
  busy  out  1  high when not in IDLE.
REQ-002 Clock and reset SHALL be named clk and rst_n; one clock; reset asynchronous, active-low.

Function
REQ-003 The block SHALL share one 8-bit ALU between two requesters under a 3-state FSM: IDLE, EXEC, DONE.
REQ-004 In IDLE with any req high at a rising edge, the block SHALL grant one requester, latch its op/da/db, and go to EXEC.
REQ-005 Arbitration SHALL be round-robin: with both requesting, grant the one not granted last; after reset requester 0 has priority.
REQ-006 In IDLE with a single requester, the block SHALL grant it regardless of the pointer; the pointer SHALL update only on grant.
REQ-007 EXEC SHALL register the ALU output into res/cout and go to DONE.
REQ-008 ALU results SHALL be as follows:
  ADD: {cout,res} = da+db, 9-bit, no saturation.
  AND: res = da&db.
  NOT: res = ~da.
  BIT0: res = {7'b0, da[0]}.
REQ-009 DONE SHALL assert res_valid, res_id and the matching ack for exactly one cycle, then return to IDLE.
REQ-010 Latency SHALL be fixed: req sampled at edge k, then res_valid/ack high during cycle k+2.
REQ-011 Throughput SHALL be one operation per 3 cycles; IDLE SHALL always last at least one cycle.
REQ-012 A requester SHALL hold req and its operands until ack; operand changes after grant SHALL be ignored.
REQ-013 A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-014 A req dropped before grant SHALL be a withdrawal with no side effects.
REQ-015 res/cout SHALL hold their value outside DONE until the next EXEC.

Reset
REQ-016 On rst_n low, the block SHALL asynchronously go to IDLE and clear outputs as follows: res=0, cout=0, res_valid=0, res_id=0, ack0=0, ack1=0, busy=0; RR pointer = favor requester 0.
REQ-017 Reset during EXEC/DONE SHALL abort the operation with no ack; the aborted request SHALL be re-arbitrated after release if req is still high.

Configuration
REQ-018 Macro ALU_ZERO_FLAG_EN, when defined, SHALL add output zero (1 bit): registered with res in EXEC, high when res==0, reset to 0.
REQ-019 Without ALU_ZERO_FLAG_EN, the zero port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-020 Opcode constants (OP_ADD, OP_AND, OP_NOT, OP_BIT0) and state encodings SHALL live in shared package alu_sched_pkg.
REQ-021 The combinational datapath SHALL be sub-module alu8_core, with inputs op, da, db and outputs res, cout; the arbiter/FSM SHALL be in the top.

Verification
REQ-022 req0, ADD, da=8'hFF, db=8'h01 -> two cycles later: res=8'h00, cout=1, res_valid=1, res_id=0, ack0 pulse; zero=1 if ALU_ZERO_FLAG_EN is defined.
REQ-023 After reset, req0 (AND 8'hF0, 8'h3C) and req1 (NOT 8'hA5) raised together -> first res=8'h30 (id 0), then res=8'h5A (id 1), 3 cycles apart.
REQ-024 req0 and req1 held continuously for 6 operations -> res_id sequence 0,1,0,1,0,1.
REQ-025 req1 BIT0, da=8'h03; da changed to 8'h02 in EXEC -> res=8'h01.
REQ-026 rst_n pulsed low during EXEC -> all outputs 0 immediately, no ack; req1 still high after release -> served from IDLE with normal latency.
REQ-027 req0 raised for one cycle while busy, then dropped before grant -> no grant, no ack0, RR pointer unchanged.
